q_5_18: RTL and testbench
=========================

Name: q_5_18

Overview:
- Two-bit synchronous up/down counter with count enable, as in Mano Digital Design problem 5.18.
- State is held in two flip-flops, A (MSB) and B (LSB).
- Input E enables counting; input F selects the direction (1 = up, 0 = down).
- The current state drives the output directly. The block is a standalone sequential exercise used as a leaf FSM.

Parameters:
- None. The width is fixed at 2 bits.

Ports:
- clk  input  1  System clock. All state changes occur on the rising edge.
- rstn  input  1  Reset, synchronous and active-low. Sampled on the rising edge of clk.
- E  input  1  Count enable. 0 = hold the current state, 1 = count.
- F  input  1  Direction select, used only when E=1. 1 = up, 0 = down.
- y_out  output  2  Current state {A,B}. y_out[1]=A, y_out[0]=B.
- Positional port order at instantiation is fixed: rstn, clk, E, F, y_out.

Behaviour:
- Single clock domain. There are no combinational paths from the inputs to y_out: y_out is a Moore output equal to the registered state.
- Reset:
  - On a rising clk edge with rstn=0, the state becomes 00 regardless of E and F.
  - There is no asynchronous clear. Between power-up and the first reset edge the state is undefined.
  - Reset has priority over counting.
- Hold: on a rising edge with rstn=1 and E=0, the state is unchanged for any F.
- Count up: on a rising edge with rstn=1, E=1, F=1, the sequence is 00->01->10->11->00 (wraps).
- Count down: on a rising edge with rstn=1, E=1, F=0, the sequence is 00->11->10->01->00 (wraps).
- Implementation uses two JK-style flip-flops with these equations:
  - JB = KB = E, so B toggles on every enabled edge.
  - JA = KA = E & (F XNOR B). A toggles when counting up with B=1, or counting down with B=0.
  - JK semantics: J=K=0 holds, J=K=1 toggles.
- The JK flip-flop is a separate submodule, instantiated twice, with its own synchronous active-low clear. An equivalent behavioural next-state is allowed only if the cycle behaviour is identical.
- Changing the direction mid-sequence takes effect on the next edge, starting from the current state. There is no restart to 00.
- If rstn is asserted mid-count, the state is 00 on that edge. Counting resumes from 00 on the first edge after rstn returns to 1.
- Latency: one clock. The effect of E, F and rstn sampled at edge n is visible on y_out immediately after edge n.

Test Plan:
- Reset: rstn=0 with E=F=0 for one edge -> y_out=00. Hold rstn=0 with E=F=1 for several edges -> y_out stays 00.
- Hold: after reset, rstn=1, apply {E,F}=01 for 8 edges, then 00 for 10 edges -> y_out=00 throughout.
- Count up: from 00, {E,F}=11 -> y_out 01,10,11,00,01 on successive edges. After 10 edges, y_out=10.
- Direction switch: from 10, set {E,F}=10 -> y_out 01,00,11,10 on successive edges. After 12 down edges from 10, y_out=10.
- Mid-count reset: while counting down at y_out=10, drive rstn=0 -> y_out=00 on that edge and stays 00 while rstn=0.
- Per-state exhaustive check: for each state 00..11 with E=1, check F=1 gives state+1 mod 4, F=0 gives state-1 mod 4, and E=0 leaves the state unchanged.

Source files
------------

// File: rtl/q_5_18_if.sv
// ============================================================================
// Module   : q_5_18_if
// Brief    : Control/state bundle for the 2-bit up/down counter q_5_18.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface q_5_18_if;
    logic       E;
    logic       F;
    logic [1:0] y_out;

    modport master (output E, output F, input  y_out);
    modport slave  (input  E, input  F, output y_out);
endinterface

`default_nettype wire

// File: rtl/q_5_18.sv
// ============================================================================
// Module   : q_5_18
// Brief    : 2-bit synchronous up/down counter with enable, built from two JK
//            flip-flops (A = MSB, B = LSB); y_out is the registered state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module q_5_18_jkff (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic j_i,
    input  wire logic k_i,
    output logic      q_o
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j_i, k_i})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

module q_5_18 (
    input  wire logic       rstn,
    input  wire logic       clk,
    input  wire logic       E,
    input  wire logic       F,
    output logic      [1:0] y_out
);
    logic w_a;
    logic w_b;
    logic w_jk_a;
    logic w_jk_b;

    // A flips on the B carry when counting up, on the B borrow when counting down.
    assign w_jk_b = E;
    assign w_jk_a = E & ~(F ^ w_b);

    q_5_18_jkff u_ff_a (
        .clk  (clk),
        .rstn (rstn),
        .j_i  (w_jk_a),
        .k_i  (w_jk_a),
        .q_o  (w_a)
    );

    q_5_18_jkff u_ff_b (
        .clk  (clk),
        .rstn (rstn),
        .j_i  (w_jk_b),
        .k_i  (w_jk_b),
        .q_o  (w_b)
    );

    assign y_out = {w_a, w_b};
endmodule

`default_nettype wire

// File: tb/tb_q_5_18.sv
// ============================================================================
// Module   : tb_q_5_18
// Brief    : Self-checking bench for q_5_18 against an arithmetic mod-4 model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_q_5_18;
    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   model;

    q_5_18_if bus ();

    q_5_18 dut (
        .rstn  (rstn),
        .clk   (clk),
        .E     (bus.E),
        .F     (bus.F),
        .y_out (bus.y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; the model follows the counting rules with plain arithmetic.
    task automatic step();
        @(posedge clk);
        if (!rstn)           model = 0;
        else if (bus.E && bus.F)  model = (model + 1) % 4;
        else if (bus.E)           model = (model + 3) % 4;
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic f);
        rstn  = r;
        bus.E = e;
        bus.F = f;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0);
        step();
        n_tests++;
        if (bus.y_out !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ef00: y_out=%b expected=00", bus.y_out);
        end
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.y_out !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold_ef11[%0d]: y_out=%b expected=00", i, bus.y_out);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b0, (i < 8) ? 1'b1 : 1'b0);
            step();
            n_tests++;
            if (bus.y_out !== 2'b00) begin
                n_fail++;
                $display("FAIL hold[%0d]: y_out=%b expected=00", i, bus.y_out);
            end
        end
    endtask

    task automatic test_count_up();
        logic [1:0] seq [5];
        seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (i < 5 && bus.y_out !== seq[i]) begin
                n_fail++;
                $display("FAIL count_up[%0d]: y_out=%b expected=%b", i, bus.y_out, seq[i]);
            end else if (i >= 5 && bus.y_out !== 2'(model)) begin
                n_fail++;
                $display("FAIL count_up[%0d]: y_out=%b expected=%0d", i, bus.y_out, model);
            end
        end
        n_tests++;
        if (bus.y_out !== 2'b10) begin
            n_fail++;
            $display("FAIL count_up_after10: y_out=%b expected=10", bus.y_out);
        end
    endtask

    task automatic test_direction_switch();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b00, 2'b11, 2'b10};
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            n_tests++;
            if (bus.y_out !== seq[i % 4]) begin
                n_fail++;
                $display("FAIL count_down[%0d]: y_out=%b expected=%b", i, bus.y_out, seq[i % 4]);
            end
        end
    endtask

    task automatic test_mid_reset();
        n_tests++;
        if (bus.y_out !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_reset_pre: y_out=%b expected=10", bus.y_out);
        end
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.y_out !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: y_out=%b expected=00", i, bus.y_out);
            end
        end
        drive(1'b1, 1'b1, 1'b1);
        step();
        n_tests++;
        if (bus.y_out !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reset_resume: y_out=%b expected=01", bus.y_out);
        end
    endtask

    task automatic test_exhaustive();
        for (int s = 0; s < 4; s++) begin
            for (int mode = 0; mode < 3; mode++) begin
                drive(1'b0, 1'b0, 1'b0);
                step();
                drive(1'b1, 1'b1, 1'b1);
                for (int k = 0; k < s; k++) step();
                if (mode == 0)      drive(1'b1, 1'b1, 1'b1);
                else if (mode == 1) drive(1'b1, 1'b1, 1'b0);
                else                drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                step();
                n_tests++;
                if (bus.y_out !== 2'((mode == 0) ? (s + 1) % 4 : (mode == 1) ? (s + 3) % 4 : s)) begin
                    n_fail++;
                    $display("FAIL exhaustive s=%0d mode=%0d: y_out=%b model=%0d", s, mode, bus.y_out, model);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            n_tests++;
            if (bus.y_out !== 2'(model)) begin
                n_fail++;
                $display("FAIL random[%0d]: y_out=%b expected=%0d", i, bus.y_out, model);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model   = 0;
        drive(1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_hold();
        test_count_up();
        test_direction_switch();
        test_mid_reset();
        test_exhaustive();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
